// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the stream_mux_rr block: arbitration mode encodings,
// the clog2 constant function and the channel-slice index macro.
// Optional feature macro used by the block: STREAM_MUX_FORCE_SEL_EN.
`ifndef STREAM_MUX_RR_PKG_SV
`define STREAM_MUX_RR_PKG_SV

// Bit range of channel <idx> inside a flat CHANNELS*WIDTH bus
`define STREAM_MUX_SLICE(idx, w) ((idx)*(w)) +: (w)

package stream_mux_rr_pkg;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Number of bits needed to encode 'value' distinct indices
   function automatic int mux_clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

`endif

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: picks one requester, either lowest index first or round-robin
// starting just after the last granted index (ptr). Produces a one-hot grant
// and the matching encoded index; nothing is granted while enable is low.
module rr_arbiter
   import stream_mux_rr_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int RR_MODE  = ARB_RR,
   localparam int SEL_W   = mux_clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [SEL_W-1:0]    ptr,
   input  logic                enable,
   output logic [CHANNELS-1:0] grant,
   output logic [SEL_W-1:0]    idx
);

   int               cand_s;
   logic [SEL_W-1:0] cand_idx_s;
   logic             hit_s;
   logic             found_s;

   // Walk the channels in priority order and grant the first requester
   always_comb begin
      grant      = '0;
      idx        = '0;
      found_s    = 1'b0;
      cand_s     = 0;
      cand_idx_s = '0;
      hit_s      = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         cand_s     = (RR_MODE == ARB_RR) ? ((int'(ptr) + 1 + k) % CHANNELS) : k;
         cand_idx_s = SEL_W'(cand_s);
         hit_s      = enable && !found_s && req[cand_idx_s];
         grant[cand_idx_s] = grant[cand_idx_s] | hit_s;
         idx        = hit_s ? cand_idx_s : idx;
         found_s    = found_s | hit_s;
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream multiplexer with a single
// registered output stage. Arbitration is fixed-priority or round-robin.
// Optional macro STREAM_MUX_FORCE_SEL_EN adds force_en/force_sel, which
// restrict eligibility to one channel without moving the round-robin pointer.
module stream_mux_rr
   import stream_mux_rr_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int RR_MODE  = ARB_RR,
   localparam int SEL_W   = mux_clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic [CHANNELS-1:0]       in_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_sel,
   input  logic                      out_ready
`ifdef STREAM_MUX_FORCE_SEL_EN
   ,
   input  logic                      force_en,
   input  logic [SEL_W-1:0]          force_sel
`endif
);

   logic                out_valid_q, out_valid_d;
   logic [WIDTH-1:0]    out_data_q,  out_data_d;
   logic [SEL_W-1:0]    out_sel_q,   out_sel_d;
   logic [SEL_W-1:0]    ptr_q,       ptr_d;

   logic                load_en_s;
   logic                load_s;
   logic                forced_s;
   logic [CHANNELS-1:0] req_s;
   logic [CHANNELS-1:0] grant_s;
   logic [SEL_W-1:0]    idx_s;
   logic [WIDTH-1:0]    in_word_s [CHANNELS];

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
         assign in_word_s[gi] = in_data[`STREAM_MUX_SLICE(gi, WIDTH)];
`ifdef STREAM_MUX_FORCE_SEL_EN
         assign req_s[gi] = in_valid[gi] & (~force_en | (force_sel == SEL_W'(gi)));
`else
         assign req_s[gi] = in_valid[gi];
`endif
      end
   endgenerate

`ifdef STREAM_MUX_FORCE_SEL_EN
   assign forced_s = force_en;
`else
   assign forced_s = 1'b0;
`endif

   // The output register may accept a word when empty or draining this cycle
   assign load_en_s = !out_valid_q || out_ready;

   rr_arbiter #(
      .CHANNELS (CHANNELS),
      .RR_MODE  (RR_MODE)
   ) u_arb (
      .req    (req_s),
      .ptr    (ptr_q),
      .enable (load_en_s && !rst),
      .grant  (grant_s),
      .idx    (idx_s)
   );

   assign in_ready = grant_s;
   assign load_s   = |grant_s;

   // Next-state for the output register and the round-robin pointer
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
      if (load_s) begin
         out_valid_d = 1'b1;
         out_data_d  = in_word_s[idx_s];
         out_sel_d   = idx_s;
         if ((RR_MODE == ARB_RR) && !forced_s) begin
            ptr_d = idx_s;
         end else begin
            ptr_d = ptr_q;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Output stage and pointer state; reset discards any held word
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= SEL_W'(CHANNELS - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: three instances (4ch round-robin, 4ch fixed
// priority, 3ch round-robin) checked every cycle against a queue-free
// behavioural model, plus directed literal expectations.
module tb_stream_mux_rr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [3:0]  v    [3];
   logic [31:0] d    [3];
   logic        ordy [3];
   logic        fen  [3];
   logic [1:0]  fsel [3];

   logic [3:0]  r0, r1;
   logic [2:0]  r2;
   logic        ov0, ov1, ov2;
   logic [7:0]  od0, od1, od2;
   logic [1:0]  os0, os1, os2;

   logic [3:0]  rdy [3];
   logic        ov  [3];
   logic [7:0]  od  [3];
   logic [1:0]  os  [3];

   always_comb begin
      rdy[0] = r0; rdy[1] = r1; rdy[2] = {1'b0, r2};
      ov[0] = ov0; ov[1] = ov1; ov[2] = ov2;
      od[0] = od0; od[1] = od1; od[2] = od2;
      os[0] = os0; os[1] = os1; os[2] = os2;
   end

   stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .RR_MODE(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(v[0]), .in_data(d[0]), .in_ready(r0),
      .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(ordy[0])
`ifdef STREAM_MUX_FORCE_SEL_EN
      , .force_en(fen[0]), .force_sel(fsel[0])
`endif
   );

   stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .RR_MODE(0)) u1 (
      .clk(clk), .rst(rst), .in_valid(v[1]), .in_data(d[1]), .in_ready(r1),
      .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(ordy[1])
`ifdef STREAM_MUX_FORCE_SEL_EN
      , .force_en(fen[1]), .force_sel(fsel[1])
`endif
   );

   stream_mux_rr #(.WIDTH(8), .CHANNELS(3), .RR_MODE(1)) u2 (
      .clk(clk), .rst(rst), .in_valid(v[2][2:0]), .in_data(d[2][23:0]), .in_ready(r2),
      .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(ordy[2])
`ifdef STREAM_MUX_FORCE_SEL_EN
      , .force_en(fen[2]), .force_sel(fsel[2])
`endif
   );

   // Behavioural model state
   int         cc  [3] = '{4, 4, 3};
   int         rrm [3] = '{1, 0, 1};
   bit         mv  [3];
   logic [7:0] md  [3];
   int         ms  [3];
   int         mp  [3];
   int         eg  [3];
   int         checks   = 0;
   int         failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Channel the specification says wins this cycle, or -1
   function automatic int calc_grant(int m);
      int  c;
      bit  elig;
      if (rst || (mv[m] && !ordy[m])) return -1;
      for (int k = 0; k < cc[m]; k++) begin
         c    = (rrm[m] != 0) ? (mp[m] + 1 + k) % cc[m] : k;
         elig = v[m][c];
`ifdef STREAM_MUX_FORCE_SEL_EN
         if (fen[m] && (int'(fsel[m]) != c)) elig = 1'b0;
`endif
         if (elig) return c;
      end
      return -1;
   endfunction

   function automatic bit is_forced(int m);
`ifdef STREAM_MUX_FORCE_SEL_EN
      return fen[m];
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 3; m++) begin
         mv[m] = 1'b0; md[m] = 8'h00; ms[m] = 0; mp[m] = cc[m] - 1;
      end
   endtask

   // Compare every output of every instance against the model
   task automatic step();
      logic [3:0] er;
      #1;
      for (int m = 0; m < 3; m++) begin
         eg[m] = calc_grant(m);
         er    = (eg[m] >= 0) ? (4'b0001 << eg[m]) : 4'b0000;
         chk($sformatf("in_ready[%0d]", m), 64'(rdy[m]), 64'(er));
         chk($sformatf("out_valid[%0d]", m), 64'(ov[m]), 64'(mv[m]));
         chk($sformatf("out_data[%0d]", m), 64'(od[m]), 64'(md[m]));
         chk($sformatf("out_sel[%0d]", m), 64'(os[m]), 64'(ms[m]));
      end
   endtask

   // Advance one clock and apply the specification's update rules
   task automatic adv();
      @(posedge clk);
      for (int m = 0; m < 3; m++) begin
         if (rst) begin
            mv[m] = 1'b0; md[m] = 8'h00; ms[m] = 0; mp[m] = cc[m] - 1;
         end else if (eg[m] >= 0) begin
            mv[m] = 1'b1;
            md[m] = d[m][eg[m]*8 +: 8];
            ms[m] = eg[m];
            if (rrm[m] != 0 && !is_forced(m)) mp[m] = eg[m];
         end else if (ordy[m]) begin
            mv[m] = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic rand_data();
      for (int m = 0; m < 3; m++) d[m] = $urandom;
   endtask

   logic [3:0] seq_rr  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [3:0] seq_wrp [5] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001};

   initial begin
      rst = 1'b1;
      for (int m = 0; m < 3; m++) begin
         v[m] = 4'h0; d[m] = 32'h0; ordy[m] = 1'b1; fen[m] = 1'b0; fsel[m] = 2'd0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();

      // Reset held: in_ready must stay low even with requests
      v[0] = 4'hF;
      step(); adv();
      rst = 1'b0; v[0] = 4'h0;

      // Idle: nothing valid, consumer ready
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_ready", 64'(r0), 64'h0);
         chk("idle_valid", 64'(ov0), 64'h0);
         adv();
      end

      // Round-robin on u0, fixed priority on u1, wrap on the 3-channel u2
      v[0] = 4'hF; v[1] = 4'b1010; v[2] = 4'b0101;
      for (int i = 0; i < 5; i++) begin
         rand_data();
         step();
         chk("rr_seq", 64'(r0), 64'(seq_rr[i]));
         chk("fixed_pri", 64'(r1), 64'h2);
         chk("wrap3", 64'(r2), 64'(seq_wrp[i]));
         adv();
         chk("rr_sel_trail", 64'(os0), 64'(i % 4));
      end

      // Backpressure on u0: hold for 3 cycles, then drain+load in one edge
      ordy[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_data();
         step();
         chk("bp_ready", 64'(r0), 64'h0);
         chk("bp_sel", 64'(os0), 64'h0);
         adv();
      end
      ordy[0] = 1'b1;
      step();
      chk("bp_release", 64'(r0), 64'h2);
      adv();
      chk("bp_reload_sel", 64'(os0), 64'h1);

`ifdef STREAM_MUX_FORCE_SEL_EN
      rst = 1'b1; v[0] = 4'h0; v[1] = 4'h0; v[2] = 4'h0;
      step(); adv();
      rst = 1'b0;
      v[2] = 4'b0101;
      step(); chk("force_pre", 64'(r2), 64'h1); adv();
      fen[2] = 1'b1; fsel[2] = 2'd2;
      step(); chk("force_ch2", 64'(r2), 64'h4); adv();
      fen[2] = 1'b0;
      step(); chk("force_ptr_kept", 64'(r2), 64'h4); adv();
      fen[2] = 1'b1; fsel[2] = 2'd3;
      step(); chk("force_oob", 64'(r2), 64'h0); adv();
      fen[2] = 1'b0;
`endif

      // Randomised traffic, backpressure and occasional reset
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(199) == 0);
         for (int m = 0; m < 3; m++) begin
            v[m]    = 4'($urandom_range(15));
            if (m == 2) v[m][3] = 1'b0;
            d[m]    = $urandom;
            ordy[m] = ($urandom_range(3) != 0);
`ifdef STREAM_MUX_FORCE_SEL_EN
            fen[m]  = ($urandom_range(4) == 0);
            fsel[m] = 2'($urandom_range(3));
`endif
         end
         step();
         adv();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
